// File: rtl/dilithium_pkg.sv
// Shared constants and coefficient/product types for the Dilithium datapath.
`default_nettype none

package dilithium_pkg;

  localparam logic [22:0] Q       = 23'd8380417;
  localparam int          COEFF_W = 23;
  localparam int          PROD_W  = 46;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [PROD_W-1:0]  prod_t;

endpackage

`default_nettype wire

// File: rtl/mod_q_correct.sv
// Maps a signed fold residue in [-(q+8198), 3q+2^16) onto its canonical representative in [0, q).
`default_nettype none

module mod_q_correct
  import dilithium_pkg::*;
(
  input  logic signed [25:0] r,
  output coeff_t             res
);

  localparam logic signed [26:0] QS = 27'(Q);
  localparam int NCAND = 6;

  logic signed [26:0] rx;
  logic signed [26:0] cand [NCAND];
  logic [NCAND-1:0]   hit;

  assign rx = 27'(r);

  // Candidate i is r + (2 - i)*q, i.e. offsets +2q, +q, 0, -q, -2q, -3q.
  for (genvar i = 0; i < NCAND; i++) begin : g_cand
    localparam int OFF = (2 - i) * int'(Q);
    assign cand[i] = rx + 27'(OFF);
    assign hit[i]  = (cand[i] >= 27'sd0) && (cand[i] < QS);
  end

  // Exactly one candidate can land in [0, q), so an OR-merge is a clean mux.
  always_comb begin
    res = '0;
    for (int i = 0; i < NCAND; i++) begin
      if (hit[i]) res = res | cand[i][COEFF_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/modmul_q_pipe.sv
// Three-stage valid/ready pipelined multiplier mod q = 2^23 - 2^13 + 1 with Solinas fold.
`default_nettype none

module modmul_q_pipe
  import dilithium_pkg::*;
#(
  parameter int TAG_W = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [22:0]      in_a,
  input  logic [22:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [22:0]      out_res,
  output logic [TAG_W-1:0] out_tag
);

  logic v1, v2, v3;
  logic en1, en2, en3;

  coeff_t           a1, b1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  prod_t            p2;
  coeff_t           res3;

  // Each stage advances when it is empty or its successor advances, so bubbles collapse.
  assign en3      = !v3 || out_ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      tag1 <= '0;
    end else if (en1) begin
      v1   <= in_valid;
      a1   <= in_a;
      b1   <= in_b;
      tag1 <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      p2   <= '0;
      tag2 <= '0;
    end else if (en2) begin
      v2   <= v1;
      p2   <= prod_t'(a1) * prod_t'(b1);
      tag2 <= tag1;
    end
  end

  // Fold uses 2^23 == 2^13 - 1 (mod q), applied twice to the upper product bits.
  logic [25:0]        fold_pos, fold_neg;
  logic signed [25:0] fold_r;
  coeff_t             fold_canon;

  assign fold_pos = 26'(p2[22:0])
                  + 26'({p2[32:23], 13'b0})
                  + 26'({p2[42:33], 13'b0})
                  + 26'({p2[45:43], 13'b0});
  assign fold_neg = 26'(p2[45:23]) + 26'(p2[45:33]) + 26'(p2[45:43]);
  assign fold_r   = signed'(fold_pos - fold_neg);

  mod_q_correct u_correct (
    .r   (fold_r),
    .res (fold_canon)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v3   <= 1'b0;
      res3 <= '0;
      tag3 <= '0;
    end else if (en3) begin
      v3   <= v2;
      res3 <= fold_canon;
      tag3 <= tag2;
    end
  end

  assign out_valid = v3;
  assign out_res   = res3;
  assign out_tag   = tag3;

endmodule

`default_nettype wire

// File: tb/tb_modmul_q_pipe.sv
// Directed and scoreboarded stimulus for modmul_q_pipe with hand-computed and modelled results.
`default_nettype none

module tb_modmul_q_pipe;

  localparam logic [22:0] QV = 23'd8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_res;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  modmul_q_pipe #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [22:0] res;
    logic [3:0]  tag;
    int          cyc;
  } ent_t;

  ent_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [22:0] cur_exp;
  bit          chk_lat  = 1'b0;
  bit          last_acc = 1'b0;
  bit          held     = 1'b0;
  logic [22:0] held_res;
  logic [3:0]  held_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] gold(input logic [22:0] a, input logic [22:0] b);
    logic [63:0] m;
    m = (64'(a) * 64'(b)) % 64'(QV);
    return m[22:0];
  endfunction

  // Observe one cycle at the falling edge: score output transfer, then record input transfer.
  task automatic sample();
    ent_t e;
    @(negedge clk);
    cyc++;
    last_acc = 1'b0;
    if (rst) begin
      sb.delete();
      held = 1'b0;
      return;
    end
    check("in_ready", {31'b0, in_ready}, {31'b0, !(sb.size() == 3 && !out_ready)});
    if (held) begin
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_res", {9'b0, out_res}, {9'b0, held_res});
      check("hold_tag", {28'b0, out_tag}, {28'b0, held_tag});
    end
    if (sb.size() == 0) check("no_spurious", {31'b0, out_valid}, 32'd0);
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check("res", {9'b0, out_res}, {9'b0, e.res});
      check("tag", {28'b0, out_tag}, {28'b0, e.tag});
      if (chk_lat) check("latency", cyc - e.cyc, 32'd3);
    end
    held     = out_valid && !out_ready;
    held_res = out_res;
    held_tag = out_tag;
    if (in_valid && in_ready) begin
      sb.push_back('{res: cur_exp, tag: in_tag, cyc: cyc});
      last_acc = 1'b1;
    end
  endtask

  task automatic drive(input bit v, input logic [22:0] a, input logic [22:0] b,
                       input logic [3:0] t, input logic [22:0] e, input bit ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    cur_exp   = e;
    out_ready = ordy;
    sample();
    @(posedge clk);
    #1;
  endtask

  // Hold an operand pair until accepted; rnd_ordy randomises the downstream handshake.
  task automatic send(input logic [22:0] a, input logic [22:0] b, input logic [3:0] t,
                      input logic [22:0] e, input bit rnd_ordy);
    int tries = 0;
    do begin
      drive(1'b1, a, b, t, e, rnd_ordy ? 1'($urandom_range(0, 1)) : 1'b1);
      tries++;
    end while (!last_acc && tries < 200);
    if (!last_acc) check("accept_timeout", {31'b0, last_acc}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      drive(1'b0, '0, '0, '0, '0, 1'b1);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [22:0] a, b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    cur_exp   = '0;

    // Reset held for two edges, then release.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_res", {9'b0, out_res}, 32'd0);
    check("rst_out_tag", {28'b0, out_tag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed corner vectors with constant downstream readiness and latency checking.
    chk_lat = 1'b1;
    send(QV - 23'd1, QV - 23'd1, 4'd5, 23'd1, 1'b0);
    drain();
    send(23'h400000, 23'd2, 4'd1, 23'd8191, 1'b0);
    send(23'd0, QV - 23'd1, 4'd2, 23'd0, 1'b0);
    send(23'd1, QV - 23'd1, 4'd3, 23'd8380416, 1'b0);
    send(23'h7fffff, 23'h7fffff, 4'd4, 23'd32764, 1'b0);
    send(QV - 23'd1, 23'd2, 4'd6, 23'd8380415, 1'b0);
    send(QV, 23'd12345, 4'd7, 23'd0, 1'b0);
    drain();
    chk_lat = 1'b0;

    // 64 back-to-back inputs against a randomly stalling sink.
    for (int i = 0; i < 64; i++) begin
      a = 23'($urandom);
      b = 23'($urandom);
      send(a, b, 4'(i), gold(a, b), 1'b1);
    end
    drain();

    // Two inputs in flight, then a one-cycle reset with in_valid still high.
    send(23'd3, 23'd5, 4'd9, 23'd15, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 23'd7, 23'd11, 4'd10, 23'd77, 1'b0);
    rst = 1'b1;
    drive(1'b1, 23'd7, 23'd11, 4'd10, 23'd77, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, '0, '0, 1'b1);

    // Random operands with random input gaps and output stalls.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, '0, '0, '0, '0, 1'($urandom_range(0, 1)));
      a = 23'($urandom);
      b = 23'($urandom);
      send(a, b, 4'($urandom), gold(a, b), 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
